// File: rtl/seq_divider_32.sv
// seq_divider_32: radix-2 restoring unsigned divider, one quotient bit per clock,
// with valid/ready handshakes on operands and results.
module seq_divider_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d, q_q, q_d, dvs_q, dvs_d, quo_q, quo_d, rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH:0]   t, d;
    logic [WIDTH-1:0] q_sh, r_nx;
    // The partial remainder stays below the divisor, so its top bit is only needed inside the step.
    assign t    = {r_q, q_q[WIDTH-1]};
    assign d    = t - {1'b0, dvs_q};
    assign q_sh = {q_q[WIDTH-2:0], ~d[WIDTH]};
    assign r_nx = d[WIDTH] ? t[WIDTH-1:0] : d[WIDTH-1:0];
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: if (in_valid) begin
                dvs_d = divisor;
                q_d   = dividend;
                r_d   = '0;
                cnt_d = CW'(WIDTH - 1);
                if (divisor == '0) begin
                    state_d = DONE;
                    quo_d   = '1;
                    rem_d   = dividend;
                    dbz_d   = 1'b1;
                end else begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                r_d   = r_nx;
                q_d   = q_sh;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                    quo_d   = q_sh;
                    rem_d   = r_nx;
                    dbz_d   = 1'b0;
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end
    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider_32.sv
// tb_seq_divider_32: directed vector table plus hand-written handshake and reset sequences.
module tb_seq_divider_32;
    logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
    logic [31:0] dividend = 0, divisor = 0;
    logic        in_ready, out_valid, div_by_zero;
    logic [31:0] quotient, remainder;
    int total = 0, bad = 0;

    seq_divider_32 dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a, b, eq, er;
        logic        edbz;
        int          elat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [31:0] a, b, eq, er, input logic edbz, input int elat,
                          input int hold, input bit poke);
        int lat;
        bit seen;
        @(negedge clk);
        chk("in_ready_before", in_ready, 1);
        dividend = a;
        divisor  = b;
        in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
        dividend = $urandom;
        divisor  = $urandom;
        lat  = 0;
        seen = 0;
        while (!seen && lat < 200) begin
            if (poke) in_valid = (lat >= 3 && lat < 6);
            @(posedge clk);
            #1 lat++;
            seen = out_valid;
        end
        in_valid = 0;
        chk("latency", lat, elat);
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        chk("div_by_zero", div_by_zero, edbz);
        for (int i = 0; i < hold; i++) begin
            if (poke) in_valid = 1;
            @(posedge clk);
            #1;
            chk("hold_out_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_quotient", quotient, eq);
            chk("hold_remainder", remainder, er);
        end
        in_valid  = 0;
        out_ready = 1;
        @(posedge clk);
        #1 out_ready = 0;
        chk("post_hs_out_valid", out_valid, 0);
        chk("post_hs_in_ready", in_ready, 1);
        chk("post_hs_quotient", quotient, eq);
        if (poke) begin
            for (int i = 0; i < 3; i++) begin
                @(posedge clk);
                #1 chk("no_extra_result", out_valid, 0);
            end
        end
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,  1'b0, 32};
        vecs[1] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,  1'b0, 32};
        vecs[2] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,  1'b0, 32};
        vecs[3] = '{32'd3,          32'd10,         32'd0,          32'd3,  1'b0, 32};
        vecs[4] = '{32'h8000_0000,  32'h10,         32'h0800_0000,  32'd0,  1'b0, 32};
        vecs[5] = '{32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,  1'b1, 1};
        vecs[6] = '{32'd9,          32'd3,          32'd3,          32'd0,  1'b0, 32};
        vecs[7] = '{32'd123456789,  32'd1000,       32'd123456,     32'd789, 1'b0, 32};

        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_div_by_zero", div_by_zero, 0);
        @(negedge clk) rst_n = 1;

        foreach (vecs[i])
            run_op(vecs[i].a, vecs[i].b, vecs[i].eq, vecs[i].er, vecs[i].edbz, vecs[i].elat, 0, 0);

        run_op(32'd1000, 32'd33, 32'd30, 32'd10, 1'b0, 32, 5, 1);

        @(negedge clk);
        dividend = 32'd1000;
        divisor  = 32'd7;
        in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
        repeat (10) @(posedge clk);
        #3 rst_n = 0;
        #1;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_quotient", quotient, 0);
        chk("abort_remainder", remainder, 0);
        chk("abort_div_by_zero", div_by_zero, 0);
        @(negedge clk) rst_n = 1;
        run_op(32'd50, 32'd6, 32'd8, 32'd2, 1'b0, 32, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_divider_32.md
Name: seq_divider_32

Overview:
Sequential unsigned integer divider, the inverse of the team's multiplier datapath. It computes quotient and remainder with a radix-2 restoring algorithm, retiring one quotient bit per clock. Operands enter and results leave through valid/ready handshakes, so the block drops into the arithmetic unit beside the Wallace-tree multiplier and the prefix adders.

Parameters:
WIDTH, 32, operand, quotient and remainder width in bits (must be >= 2).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  dividend/divisor valid
in_ready  output  1  block can accept an operation
dividend  input  WIDTH  unsigned dividend
divisor  input  WIDTH  unsigned divisor
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
quotient  output  WIDTH  unsigned quotient
remainder  output  WIDTH  unsigned remainder
div_by_zero  output  1  set with result when divisor was 0

Behaviour:
- Reset (rst_n low, asynchronous):
  - state goes to IDLE.
  - in_ready=1, out_valid=0.
  - quotient, remainder and div_by_zero are 0.
  - Internal shift registers and the iteration counter are cleared.
- States are IDLE, BUSY and DONE.
- in_ready=1 only in IDLE. in_valid, dividend and divisor are ignored in BUSY and DONE.
- Acceptance happens on a rising edge with in_valid&&in_ready.
  - Operands are latched.
  - If divisor!=0: partial remainder R (WIDTH+1 bits) is set to 0, quotient shift register Q is set to dividend, counter is set to WIDTH-1, and the state goes to BUSY.
  - If divisor==0: the state goes straight to DONE with quotient=all ones, remainder=dividend and div_by_zero=1. out_valid is visible 1 cycle after the acceptance edge.
- Each BUSY cycle:
  - T = {R[WIDTH-1:0], Q[WIDTH-1]}.
  - D = T - {1'b0, divisor}, computed at WIDTH+1 bits.
  - If D[WIDTH]==0: R=D, and Q shifts left with LSB 1.
  - Otherwise: R=T, and Q shifts left with LSB 0.
  - Counter decrements.
  - On the cycle with counter==0, the state goes to DONE; quotient=Q after the shift and remainder=R[WIDTH-1:0] after the step are registered; div_by_zero=0.
- Latency, nonzero divisor: out_valid rises exactly WIDTH cycles after the acceptance edge (32 for the default).
- DONE:
  - out_valid=1.
  - quotient, remainder and div_by_zero are held stable until out_valid&&out_ready.
  - On that edge the state goes to IDLE and out_valid drops.
  - After the handshake, the outputs keep their last values until the next completion.
- No overlap: a new operation can be accepted no earlier than the cycle after the result handshake.
- Invariant on completion: dividend == quotient*divisor + remainder, with remainder < divisor whenever divisor != 0.
- Reset mid-operation (BUSY or DONE) aborts immediately and returns all outputs to their reset values. No result is emitted for the aborted operation.
- out_ready asserted outside DONE has no effect.

Test Plan:
- dividend=100, divisor=7 -> out_valid 32 cycles after acceptance; quotient=14, remainder=2, div_by_zero=0.
- dividend=0xFFFFFFFF, divisor=1 -> quotient=0xFFFFFFFF, remainder=0. Also dividend=0xFFFFFFFF, divisor=0xFFFFFFFF -> quotient=1, remainder=0.
- dividend=3, divisor=10 -> quotient=0, remainder=3. Also dividend=0x80000000, divisor=0x10 -> quotient=0x08000000, remainder=0.
- dividend=5, divisor=0 -> out_valid 1 cycle after acceptance; quotient=0xFFFFFFFF, remainder=5, div_by_zero=1. Follow with 9/3 -> div_by_zero=0, quotient=3, remainder=0.
- 1000/33 with out_ready held low 5 cycles after out_valid -> quotient=30 and remainder=10 held stable throughout; in_ready stays 0; in_valid pulsed during BUSY/DONE creates no extra result.
- Reset pulse at cycle 10 of BUSY -> in_ready=1, out_valid=0 and all outputs 0 immediately. A subsequent 50/6 completes normally with quotient=8, remainder=2.
